// File: rtl/permutation_canonical_reducer_pkg.sv
// Shared constants for the permutation pipeline (generator -> canonical
// reducer -> dedup). The result record layout is the one the dedup stage
// unpacks, so its field widths live here rather than in any one module.
package permutation_canonical_reducer_pkg;

    localparam int BOT_WIDTH          = 128;
    localparam int PERMUTS_PER_SERIES = 42;   // 7 x 6 permutations per input bot
    localparam int CNT_WIDTH          = 6;
    localparam int IDX_WIDTH          = 32;

    typedef struct packed {
        logic [BOT_WIDTH-1:0] canonical_bot;
        logic [CNT_WIDTH-1:0] stab_count;
        logic [CNT_WIDTH-1:0] element_count;
        logic [IDX_WIDTH-1:0] series_index;
        logic                 count_error;
    } series_result_t;

endpackage

// File: rtl/permutation_canonical_reducer_bot_compare_unsigned.sv
// Unsigned magnitude/equality compare of two bots.
// Ports:
//   a, b : WIDTH-bit operands
//   lt   : a < b (unsigned)
//   eq   : a == b
// The compare is split into upper and lower halves so a register can later
// be dropped between the half compares and the final combine if timing
// requires it.
module bot_compare_unsigned
    import permutation_canonical_reducer_pkg::*;
#(
    parameter int WIDTH = BOT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq
);

    localparam int HALF = WIDTH / 2;

    logic hi_lt;
    logic hi_eq;
    logic lo_lt;
    logic lo_eq;

    always_comb begin
        hi_lt = (a[WIDTH-1:HALF] <  b[WIDTH-1:HALF]);
        hi_eq = (a[WIDTH-1:HALF] == b[WIDTH-1:HALF]);
        lo_lt = (a[HALF-1:0]     <  b[HALF-1:0]);
        lo_eq = (a[HALF-1:0]     == b[HALF-1:0]);
        lt    = hi_lt | (hi_eq & lo_lt);
        eq    = hi_eq & lo_eq;
    end

endmodule

// File: rtl/permutation_canonical_reducer.sv
// Reduces each series of permuted bots to its canonical (unsigned-minimum)
// bot and the number of permutations equal to that minimum.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   inBot, inBotValid   : permuted bot stream from the generator
//   inSeriesFinished    : one-cycle pulse closing the current series
//   outCanonicalBot     : minimum bot of the closed series (all-ones if empty)
//   outStabCount        : elements equal to the minimum (saturating)
//   outElementCount     : elements in the series (saturating)
//   outSeriesIndex      : running series index, wraps
//   outValid            : one-cycle result strobe
//   outCountError       : with outValid, element count != EXPECTED_COUNT
// Pipeline: input register stage, accumulator stage, output registers.
// A finish pulse in cycle n yields outValid in cycle n+2.
module permutation_canonical_reducer
    import permutation_canonical_reducer_pkg::*;
#(
    parameter int BOT_W          = BOT_WIDTH,
    parameter int EXPECTED_COUNT = PERMUTS_PER_SERIES,
    parameter int CNT_W          = CNT_WIDTH,
    parameter int IDX_W          = IDX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BOT_W-1:0] inBot,
    input  logic             inBotValid,
    input  logic             inSeriesFinished,
    output logic [BOT_W-1:0] outCanonicalBot,
    output logic [CNT_W-1:0] outStabCount,
    output logic [CNT_W-1:0] outElementCount,
    output logic [IDX_W-1:0] outSeriesIndex,
    output logic             outValid,
    output logic             outCountError
);

    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECTED_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Input stage
    logic [BOT_W-1:0] a_bot_q, a_bot_d;
    logic             a_valid_q, a_valid_d;
    logic             a_fin_q, a_fin_d;

    // Accumulator stage; acc_empty_q marks "no element yet" so that an
    // all-ones bot is an ordinary value rather than a sentinel.
    logic [BOT_W-1:0] acc_min_q, acc_min_d;
    logic [CNT_W-1:0] acc_stab_q, acc_stab_d;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;
    logic             acc_empty_q, acc_empty_d;
    logic [IDX_W-1:0] series_idx_q, series_idx_d;

    // Output registers
    logic [BOT_W-1:0] out_bot_q, out_bot_d;
    logic [CNT_W-1:0] out_stab_q, out_stab_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             out_err_q, out_err_d;

    logic bot_lt;
    logic bot_eq;

    bot_compare_unsigned #(
        .WIDTH (BOT_W)
    ) u_cmp (
        .a  (a_bot_q),
        .b  (acc_min_q),
        .lt (bot_lt),
        .eq (bot_eq)
    );

    always_comb begin
        a_bot_d      = inBot;
        a_valid_d    = inBotValid;
        a_fin_d      = inSeriesFinished;

        acc_min_d    = acc_min_q;
        acc_stab_d   = acc_stab_q;
        acc_count_d  = acc_count_q;
        acc_empty_d  = acc_empty_q;
        series_idx_d = series_idx_q;

        out_bot_d    = out_bot_q;
        out_stab_d   = out_stab_q;
        out_count_d  = out_count_q;
        out_idx_d    = out_idx_q;
        out_err_d    = out_err_q;
        out_valid_d  = 1'b0;

        if (a_fin_q) begin
            // Close uses the accumulator as it stands; an element arriving
            // alongside the finish opens the next series instead.
            out_bot_d    = acc_empty_q ? '1 : acc_min_q;
            out_stab_d   = acc_stab_q;
            out_count_d  = acc_count_q;
            out_idx_d    = series_idx_q;
            out_err_d    = (acc_count_q != EXP_CNT);
            out_valid_d  = 1'b1;
            series_idx_d = series_idx_q + IDX_W'(1);

            if (a_valid_q) begin
                acc_min_d   = a_bot_q;
                acc_stab_d  = CNT_ONE;
                acc_count_d = CNT_ONE;
                acc_empty_d = 1'b0;
            end else begin
                acc_stab_d  = '0;
                acc_count_d = '0;
                acc_empty_d = 1'b1;
            end
        end else if (a_valid_q) begin
            if (acc_empty_q || bot_lt) begin
                acc_min_d   = a_bot_q;
                acc_stab_d  = CNT_ONE;
                acc_empty_d = 1'b0;
            end else if (bot_eq && (acc_stab_q != CNT_MAX)) begin
                acc_stab_d  = acc_stab_q + CNT_ONE;
            end
            if (acc_count_q != CNT_MAX) begin
                acc_count_d = acc_count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_bot_q      <= '0;
            a_valid_q    <= 1'b0;
            a_fin_q      <= 1'b0;
            acc_min_q    <= '0;
            acc_stab_q   <= '0;
            acc_count_q  <= '0;
            acc_empty_q  <= 1'b1;
            series_idx_q <= '0;
            out_bot_q    <= '0;
            out_stab_q   <= '0;
            out_count_q  <= '0;
            out_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            a_bot_q      <= a_bot_d;
            a_valid_q    <= a_valid_d;
            a_fin_q      <= a_fin_d;
            acc_min_q    <= acc_min_d;
            acc_stab_q   <= acc_stab_d;
            acc_count_q  <= acc_count_d;
            acc_empty_q  <= acc_empty_d;
            series_idx_q <= series_idx_d;
            out_bot_q    <= out_bot_d;
            out_stab_q   <= out_stab_d;
            out_count_q  <= out_count_d;
            out_idx_q    <= out_idx_d;
            out_valid_q  <= out_valid_d;
            out_err_q    <= out_err_d;
        end
    end

    assign outCanonicalBot = out_bot_q;
    assign outStabCount    = out_stab_q;
    assign outElementCount = out_count_q;
    assign outSeriesIndex  = out_idx_q;
    assign outValid        = out_valid_q;
    assign outCountError   = out_err_q;

endmodule

// File: tb/tb_permutation_canonical_reducer.sv
// Bench for permutation_canonical_reducer. Expected results are pushed to a
// queue at each finish pulse; a monitor collects every outValid strobe and
// each scenario pops and compares them.
module tb_permutation_canonical_reducer;

    localparam int BW = 128;
    localparam int CW = 6;
    localparam int IW = 32;
    localparam logic [BW-1:0] ALL1 = {BW{1'b1}};

    typedef struct packed {
        logic [BW-1:0] bot;
        logic [CW-1:0] stab;
        logic [CW-1:0] cnt;
        logic [IW-1:0] idx;
        logic          err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] inBot = '0;
    logic          inBotValid = 1'b0;
    logic          inSeriesFinished = 1'b0;
    logic [BW-1:0] outCanonicalBot;
    logic [CW-1:0] outStabCount;
    logic [CW-1:0] outElementCount;
    logic [IW-1:0] outSeriesIndex;
    logic          outValid;
    logic          outCountError;

    res_t exp_q[$];
    res_t obs_q[$];
    int   exp_cyc_q[$];
    int   obs_cyc_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [IW-1:0] exp_idx = '0;

    permutation_canonical_reducer dut (
        .clk              (clk),
        .rst              (rst),
        .inBot            (inBot),
        .inBotValid       (inBotValid),
        .inSeriesFinished (inSeriesFinished),
        .outCanonicalBot  (outCanonicalBot),
        .outStabCount     (outStabCount),
        .outElementCount  (outElementCount),
        .outSeriesIndex   (outSeriesIndex),
        .outValid         (outValid),
        .outCountError    (outCountError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (outValid === 1'b1) begin
            obs_q.push_back('{outCanonicalBot, outStabCount, outElementCount,
                              outSeriesIndex, outCountError});
            obs_cyc_q.push_back(cyc);
        end
    end

    function automatic string fmt(input res_t r);
        return $sformatf("bot=%h stab=%0d cnt=%0d idx=%0d err=%b",
                         r.bot, r.stab, r.cnt, r.idx, r.err);
    endfunction

    task automatic drive(input logic [BW-1:0] b, input logic v, input logic f);
        @(posedge clk);
        #1;
        rst              = 1'b0;
        inBot            = b;
        inBotValid       = v;
        inSeriesFinished = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, 1'b0, 1'b0);
    endtask

    // Drive a finish pulse (optionally with a bot for the next series) and
    // queue the result the closed series must produce.
    task automatic finish(input logic [BW-1:0] b, input logic v,
                          input logic [BW-1:0] e_bot, input int e_stab, input int e_cnt);
        res_t e;
        drive(b, v, 1'b1);
        e.bot  = e_bot;
        e.stab = CW'(e_stab);
        e.cnt  = CW'(e_cnt);
        e.idx  = exp_idx;
        e.err  = (e_cnt != 42);
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc);
        exp_idx = exp_idx + 1;
    endtask

    task automatic get_result(output bit ok, output res_t o, output int oc);
        ok = 1'b0;
        o  = '0;
        oc = 0;
        for (int i = 0; i < 16; i++) begin
            if (obs_q.size() > 0) begin
                o  = obs_q.pop_front();
                oc = obs_cyc_q.pop_front();
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        inSeriesFinished = 1'b1;     // finish during reset must be ignored
        @(posedge clk);
        #1;
        rst = 1'b0;
        inSeriesFinished = 1'b0;
        idle(4);
        @(negedge clk);
        n_cmp++;
        if (outValid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", outValid); end
        n_cmp++;
        if (outCountError !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b want 0", outCountError); end
        n_cmp++;
        if (outCanonicalBot !== '0) begin n_mis++; $display("FAIL reset_bot: got %h want 0", outCanonicalBot); end
        n_cmp++;
        if (outStabCount !== '0 || outElementCount !== '0 || outSeriesIndex !== '0) begin
            n_mis++;
            $display("FAIL reset_counts: got stab=%0d cnt=%0d idx=%0d want 0/0/0",
                     outStabCount, outElementCount, outSeriesIndex);
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_mis++; $display("FAIL reset_finish_ignored: got %0d results want 0", obs_q.size()); end
    endtask

    task automatic test_full_series();
        bit ok; res_t o, e; int oc, ec;
        for (int i = 0; i < 42; i++) drive(BW'(100 + i), 1'b1, 1'b0);
        idle(1);
        finish('0, 1'b0, BW'(100), 1, 42);
        idle(1);
        get_result(ok, o, oc);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL full_series: no outValid, want %s", fmt(e)); end
        else begin
            if (o !== e) begin n_mis++; $display("FAIL full_series: got %s want %s", fmt(o), fmt(e)); end
            n_cmp++;
            if (oc - ec != 2) begin n_mis++; $display("FAIL full_series_latency: got %0d want 2", oc - ec); end
        end
        idle(3);
        @(negedge clk);
        n_cmp++;
        if (outValid !== 1'b0 || outCanonicalBot !== BW'(100) || outElementCount !== CW'(42)) begin
            n_mis++;
            $display("FAIL hold: got valid=%b bot=%h cnt=%0d want 0/64/42",
                     outValid, outCanonicalBot, outElementCount);
        end
    endtask

    task automatic test_stab_count();
        bit ok; res_t o, e; int oc, ec;
        logic [BW-1:0] vals [42];
        logic [BW-1:0] t;
        int j;
        for (int i = 0; i < 42; i++) vals[i] = (i < 6) ? BW'(5) : BW'(7 + $urandom_range(0, 500));
        for (int i = 41; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = vals[i]; vals[i] = vals[j]; vals[j] = t;
        end
        for (int i = 0; i < 42; i++) drive(vals[i], 1'b1, 1'b0);
        finish('0, 1'b0, BW'(5), 6, 42);
        idle(1);
        get_result(ok, o, oc);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL stab_count: no outValid, want %s", fmt(e)); end
        else begin
            if (o !== e) begin n_mis++; $display("FAIL stab_count: got %s want %s", fmt(o), fmt(e)); end
            n_cmp++;
            if (oc - ec != 2) begin n_mis++; $display("FAIL stab_latency: got %0d want 2", oc - ec); end
        end
    endtask

    task automatic test_boundary();
        bit ok; res_t o, e; int oc, ec;
        for (int i = 0; i < 42; i++) drive(ALL1, 1'b1, 1'b0);
        idle(1);
        finish('0, 1'b0, ALL1, 42, 42);
        idle(1);
        for (int i = 0; i < 41; i++) drive(BW'(1000 + i) | (BW'(1) << 100), 1'b1, 1'b0);
        drive('0, 1'b1, 1'b0);
        idle(1);
        finish('0, 1'b0, '0, 1, 42);
        idle(1);
        for (int r = 0; r < 2; r++) begin
            get_result(ok, o, oc);
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            n_cmp++;
            if (!ok) begin n_mis++; $display("FAIL boundary[%0d]: no outValid, want %s", r, fmt(e)); end
            else if (o !== e) begin n_mis++; $display("FAIL boundary[%0d]: got %s want %s", r, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_error_empty();
        bit ok; res_t o, e; int oc, ec;
        for (int i = 0; i < 41; i++) drive(BW'(200 + i), 1'b1, 1'b0);
        finish('0, 1'b0, BW'(200), 1, 41);
        finish('0, 1'b0, ALL1, 0, 0);
        idle(1);
        for (int r = 0; r < 2; r++) begin
            get_result(ok, o, oc);
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            n_cmp++;
            if (!ok) begin n_mis++; $display("FAIL error_empty[%0d]: no outValid, want %s", r, fmt(e)); end
            else begin
                if (o !== e) begin n_mis++; $display("FAIL error_empty[%0d]: got %s want %s", r, fmt(o), fmt(e)); end
                n_cmp++;
                if (oc - ec != 2) begin n_mis++; $display("FAIL error_empty_latency[%0d]: got %0d want 2", r, oc - ec); end
            end
        end
    endtask

    task automatic test_overlap();
        bit ok; res_t o, e; int oc, ec;
        for (int i = 0; i < 42; i++) drive(BW'(44 - i), 1'b1, 1'b0);
        finish(BW'(7), 1'b1, BW'(3), 1, 42);
        for (int i = 0; i < 41; i++) drive(BW'(9 + i), 1'b1, 1'b0);
        idle(1);
        finish('0, 1'b0, BW'(7), 1, 42);
        idle(1);
        for (int r = 0; r < 2; r++) begin
            get_result(ok, o, oc);
            e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
            n_cmp++;
            if (!ok) begin n_mis++; $display("FAIL overlap[%0d]: no outValid, want %s", r, fmt(e)); end
            else if (o !== e) begin n_mis++; $display("FAIL overlap[%0d]: got %s want %s", r, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_saturation();
        bit ok; res_t o, e; int oc, ec;
        for (int i = 0; i < 70; i++) drive(BW'(9), 1'b1, 1'b0);
        finish('0, 1'b0, BW'(9), 63, 63);
        idle(1);
        get_result(ok, o, oc);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL saturation: no outValid, want %s", fmt(e)); end
        else if (o !== e) begin n_mis++; $display("FAIL saturation: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_reset_mid();
        bit ok; res_t o, e; int oc, ec;
        for (int i = 0; i < 20; i++) drive(BW'(1 + i), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        inBotValid = 1'b0;
        inSeriesFinished = 1'b0;
        idle(6);
        exp_idx = '0;
        n_cmp++;
        if (obs_q.size() != 0) begin n_mis++; $display("FAIL reset_mid_no_output: got %0d results want 0", obs_q.size()); end
        for (int i = 0; i < 42; i++) drive(BW'(541 - i), 1'b1, 1'b0);
        finish('0, 1'b0, BW'(500), 1, 42);
        idle(1);
        get_result(ok, o, oc);
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        n_cmp++;
        if (!ok) begin n_mis++; $display("FAIL reset_mid_series: no outValid, want %s", fmt(e)); end
        else if (o !== e) begin n_mis++; $display("FAIL reset_mid_series: got %s want %s", fmt(o), fmt(e)); end
    endtask

    initial begin
        test_reset();
        test_full_series();
        test_stab_count();
        test_boundary();
        test_error_empty();
        test_overlap();
        test_saturation();
        test_reset_mid();
        idle(4);
        n_cmp++;
        if (obs_q.size() != 0) begin n_mis++; $display("FAIL spurious_outputs: got %0d extra results want 0", obs_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/permutation_canonical_reducer.md
Name: permutation_canonical_reducer

Overview:
- Sits directly downstream of the 6/7-variable permutation generator.
- Consumes the stream of 42 permuted 128-bit bots per input bot, plus its series-finished pulse.
- Reduces each series to a canonical form (unsigned-minimum bot) and a stabiliser count (number of permutations equal to that minimum).
- Emits one result per series to the canonicalisation/dedup stage and flags series whose element count is wrong.

Parameters:
- BOT_WIDTH, 128, width of one bot.
- EXPECTED_COUNT, 42, permutations per series (7 x 6).
- CNT_WIDTH, 6, width of element and stabiliser counters; counters saturate at 2^CNT_WIDTH-1.
- IDX_WIDTH, 32, width of the series index counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- inBot  in  BOT_WIDTH  permuted bot from generator
- inBotValid  in  1  inBot valid this cycle
- inSeriesFinished  in  1  single-cycle pulse closing the current series
- outCanonicalBot  out  BOT_WIDTH  minimum bot of the closed series
- outStabCount  out  CNT_WIDTH  number of elements equal to outCanonicalBot
- outElementCount  out  CNT_WIDTH  elements received in the series (saturating)
- outSeriesIndex  out  IDX_WIDTH  index of the closed series, starting at 0, wraps
- outValid  out  1  single-cycle pulse, result valid
- outCountError  out  1  qualified by outValid; outElementCount != EXPECTED_COUNT

Behaviour:
- No backpressure. Every input cycle is accepted.
- Stage A registers inBot, inBotValid and inSeriesFinished.
- Stage B holds the accumulator: accMin, accStab, accCount, accEmpty. Output registers follow.
- Reset:
  - A-stage valid and finished cleared; accEmpty=1; accStab=0; accCount=0; seriesIdx=0.
  - outValid=0, outCountError=0, outCanonicalBot=0, outStabCount=0, outElementCount=0, outSeriesIndex=0.
- Accumulate, on A.valid:
  - If accEmpty: accMin=bot, accStab=1, accEmpty=0.
  - Else if bot < accMin (unsigned, full width): accMin=bot, accStab=1.
  - Else if bot == accMin: accStab+=1, saturating.
  - accCount+=1 in every case, saturating.
- Close, on A.finished:
  - Output registers load accMin, accStab, accCount, seriesIdx and the error compare.
  - outValid=1 for exactly one cycle; seriesIdx+=1, wrapping.
  - Accumulator is reinitialised.
- Simultaneous A.valid and A.finished:
  - The element belongs to the NEXT series.
  - The closed result excludes it.
  - The accumulator restarts as if that element were the first: accMin=bot, accStab=1, accCount=1, accEmpty=0.
- Latency: inSeriesFinished high in cycle n gives outValid high in cycle n+2.
  - All elements with inBotValid in cycles < n are included.
- Empty series (finish with no elements): outCanonicalBot=all-ones, outStabCount=0, outElementCount=0, outCountError=1.
- Output data registers hold their value between outValid pulses.
- Back-to-back finish pulses produce back-to-back results; an interior one is an empty series.
- Reset mid-series discards the partial accumulation and produces no output.
- A finish pulse in the cycle rst is asserted is ignored.
- A bot equal to all-ones is handled correctly; accEmpty, not an all-ones sentinel, marks "no element yet".

Decomposition:
- Shared header/package holds BOT_WIDTH, PERMUTS_PER_SERIES (=42) and the result-record field widths; the generator and the dedup stage use the same constants.
- One natural sub-module: bot_compare_unsigned.
  - Combinational; BOT_WIDTH inputs a, b; outputs lt, eq.
  - Internally splits into 64-bit halves (hiLt | hiEq&loLt) so the path can be retimed later.
- Counters and the FSM-free accumulator stay in the top module.

Test Plan:
- Full series: 42 valid bots with values 100..141, one idle cycle, finish pulse -> 2 cycles later outValid=1, canonical=100, stab=1, count=42, error=0, index=0.
- Stabiliser count: 42 bots with six copies of 0x5 and the rest >= 0x7, in random order -> canonical=0x5, stab=6, count=42, error=0.
- Boundary values: first bot all-ones, remaining 41 also all-ones -> canonical=all-ones, stab=42. Next series: bot 0 at position 41 only -> canonical=0, stab=1, index=1.
- Error and empty series:
  - 41 bots then finish -> count=41, error=1.
  - Immediate second finish -> canonical=all-ones, stab=0, count=0, error=1, index increments per pulse.
- Overlap: finish and valid(bot=7) in the same cycle after a series with minimum 3 -> closed result canonical=3 excluding 7. The next series, closed after 41 more bots >= 9, reports canonical=7, count=42.
- Reset: assert rst after 20 bots -> no outValid. The following complete 42-bot series reports index=0, count=42.
